// File: rtl/alu_issue_ctrl_pkg.sv
// Shared decode constants, FSM state and decode record for the ALU issue/writeback controller.
package alu_issue_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_LSH   = 4'h8;
    localparam logic [3:0] OP_LUI   = 4'hF;

    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ADDU = 4'h6;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;

    localparam logic [3:0] EXT_LSH_IMM = 4'h0;
    localparam logic [3:0] EXT_ASH_IMM = 4'h1;
    localparam logic [3:0] EXT_LSH_REG = 4'h4;

    localparam int PSR_LOW  = 1;
    localparam int PSR_FLAG = 2;
    localparam int PSR_EQ   = 3;
    localparam int PSR_NEG  = 4;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    typedef enum logic {B_REG, B_IMM} b_sel_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  a_sel;
        b_sel_t      b_sel;
        logic [15:0] imm;
        logic        writes;
        logic        illegal;
    } decode_t;

    // Codes shared by the RType ext field and the IType major field.
    function automatic logic is_alu_code(input logic [3:0] code);
        case (code)
            EXT_AND, EXT_OR, EXT_XOR, EXT_ADD,
            EXT_ADDU, EXT_SUB, EXT_CMP, EXT_MOV: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_logical(input logic [3:0] code);
        return (code == EXT_AND) || (code == EXT_OR) || (code == EXT_XOR);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake between the sequencer (master) and the issue controller (slave).
interface alu_issue_ctrl_if;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;

    modport master (output inst, output inst_valid, input inst_ready);
    modport slave  (input inst, input inst_valid, output inst_ready);
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational instruction decoder: 16-bit word to ALU opcode, operand selects and writeback flag.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int IMM_SEXT = 1
) (
    input  logic [15:0] inst,
    output decode_t     dec
);

    logic [3:0] maj;
    logic [3:0] ext;
    logic [3:0] src;
    logic [7:0] imm8;

    assign maj  = inst[15:12];
    assign ext  = inst[7:4];
    assign src  = inst[3:0];
    assign imm8 = inst[7:0];

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec         = '0;
        dec.a_sel   = inst[11:8];
        dec.b_sel   = B_REG;
        dec.illegal = 1'b1;

        case (maj)
            OP_RTYPE: begin
                if (is_alu_code(ext)) begin
                    dec.opcode  = {4'h0, ext};
                    dec.writes  = (ext != EXT_CMP);
                    dec.illegal = 1'b0;
                end
            end
            OP_LSH: begin
                if (ext == EXT_LSH_IMM || ext == EXT_ASH_IMM) begin
                    dec.opcode  = {OP_LSH, ext};
                    dec.b_sel   = B_IMM;
                    dec.imm     = {12'h000, src};
                    dec.writes  = 1'b1;
                    dec.illegal = 1'b0;
                end else if (ext == EXT_LSH_REG) begin
                    dec.opcode  = {OP_LSH, ext};
                    dec.writes  = 1'b1;
                    dec.illegal = 1'b0;
                end
            end
            OP_LUI: begin
                dec.opcode  = 8'hF0;
                dec.b_sel   = B_IMM;
                dec.imm     = {8'h00, imm8};
                dec.writes  = 1'b1;
                dec.illegal = 1'b0;
            end
            default: begin
                if (is_alu_code(maj)) begin
                    dec.opcode  = {4'h0, maj};
                    dec.b_sel   = B_IMM;
                    // Logical immediates are masks, so they never sign-extend.
                    dec.imm     = (IMM_SEXT != 0 && !is_logical(maj)) ? {{8{imm8[7]}}, imm8}
                                                                      : {8'h00, imm8};
                    dec.writes  = (maj != EXT_CMP);
                    dec.illegal = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/writeback controller: decode, operand fetch, 3-cycle serial execute, register writeback.
// Defining ALU_ISSUE_ILLEGAL_TRAP_EN adds a sticky trap output that blocks issue after an illegal decode.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IMM_SEXT = 1
) (
    input  logic              clock,
    input  logic              reset,
    alu_issue_ctrl_if.slave   issue,
    output logic [7:0]        alu_opcode,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    input  logic [15:0]       alu_result,
    input  logic [4:0]        alu_psr,
    output logic [4:0]        psr,
    output logic              wb_valid,
    output logic [3:0]        wb_addr,
    output logic [15:0]       wb_data,
    output logic              illegal,
    input  logic [3:0]        dbg_addr,
    output logic [15:0]       dbg_data
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    output logic              trap
`endif
);

    state_t      state;
    state_t      state_next;
    decode_t     dec;
    logic [15:0] rf [NUM_REGS];
    logic [3:0]  wb_dest;
    logic        wb_en;
    logic        open;
    logic        accept;

    alu_issue_decode #(.IMM_SEXT(IMM_SEXT)) u_decode (
        .inst (issue.inst),
        .dec  (dec)
    );

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign open = (state == IDLE) && !trap;
`else
    assign open = (state == IDLE);
`endif
    assign issue.inst_ready = open;
    assign accept           = issue.inst_valid && open;
    assign dbg_data         = rf[dbg_addr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !dec.illegal) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            alu_opcode <= 8'h00;
            alu_a      <= '0;
            alu_b      <= '0;
            psr        <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            illegal    <= 1'b0;
            wb_dest    <= '0;
            wb_en      <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            trap       <= 1'b0;
`endif
            // NOTE: the register file is a flop array with architectural reset to zero, so it is cleared here.
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec.illegal) begin
                            illegal <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                            trap    <= 1'b1;
`endif
                        end else begin
                            alu_opcode <= dec.opcode;
                            alu_a      <= rf[dec.a_sel];
                            alu_b      <= (dec.b_sel == B_IMM) ? dec.imm : rf[issue.inst[3:0]];
                            wb_dest    <= dec.a_sel;
                            wb_en      <= dec.writes;
                        end
                    end
                end
                // The ALU samples at the end of EXEC, so the opcode returns to idle right here.
                EXEC: alu_opcode <= 8'h00;
                WB: begin
                    alu_opcode <= 8'h00;
                    psr        <= alu_psr;
                    if (wb_en) begin
                        rf[wb_dest] <= alu_result;
                        wb_valid    <= 1'b1;
                        wb_addr     <= wb_dest;
                        wb_data     <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural registered ALU model.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    typedef struct {
        logic [15:0] inst;
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } issue_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result = '0;
    logic [4:0]  alu_psr = '0;
    logic [4:0]  psr;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        illegal;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic        trap;
`endif

    issue_t issue_q[$];
    wb_t    wb_q[$];
    vec_t   vecs[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    alu_issue_ctrl_if bus ();

    always #5 clock = ~clock;

    alu_issue_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .issue      (bus),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_psr    (alu_psr),
        .psr        (psr),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        ,
        .trap       (trap)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            8'h01:        return a & b;
            8'h02:        return a | b;
            8'h03:        return a ^ b;
            8'h05, 8'h06: return a + b;
            8'h09, 8'h0B: return a - b;
            8'h0D:        return b;
            8'h80, 8'h84: return a << b[3:0];
            8'h81:        return $unsigned($signed(a) >>> b[3:0]);
            8'hF0:        return {b[7:0], 8'h00};
            default:      return 16'h0000;
        endcase
    endfunction

    function automatic logic [4:0] psr_fn(input logic [15:0] a, input logic [15:0] b);
        return {($signed(a) < $signed(b)), (a == b), 1'b0, (a < b), 1'b0};
    endfunction

    // Registered ALU: samples whatever the controller drives and answers one cycle later.
    always @(posedge clock) begin
        alu_result <= alu_fn(alu_opcode, alu_a, alu_b);
        alu_psr    <= psr_fn(alu_a, alu_b);
    end

    always @(negedge clock) begin
        issue_t ie;
        wb_t    we;
        if (alu_opcode !== 8'h00) begin
            if (issue_q.size() == 0) check("unexpected_issue", {24'h0, alu_opcode}, 32'h0);
            else begin
                ie = issue_q.pop_front();
                check("alu_opcode", {24'h0, alu_opcode}, {24'h0, ie.op});
                check("alu_a", {16'h0, alu_a}, {16'h0, ie.a});
                check("alu_b", {16'h0, alu_b}, {16'h0, ie.b});
            end
        end
        if (wb_valid !== 1'b0) begin
            if (wb_q.size() == 0) check("unexpected_wb", {31'h0, wb_valid}, 32'h0);
            else begin
                we = wb_q.pop_front();
                check("wb_addr", {28'h0, wb_addr}, {28'h0, we.addr});
                check("wb_data", {16'h0, wb_data}, {16'h0, we.data});
            end
        end
    end

    function automatic vec_t mk(input logic [15:0] inst, input logic [7:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic wr, input logic [3:0] addr,
                                input logic [15:0] data);
        vec_t v;
        v.inst = inst; v.op = op; v.a = a; v.b = b; v.wr = wr; v.addr = addr; v.data = data;
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.inst_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'h0, 32'h1);
    endtask

    // Drives one instruction and returns at the negedge where its writeback is visible.
    task automatic run_inst(input vec_t v);
        issue_t ie;
        wb_t    we;
        wait_ready();
        ie.op = v.op; ie.a = v.a; ie.b = v.b;
        issue_q.push_back(ie);
        if (v.wr) begin
            we.addr = v.addr; we.data = v.data;
            wb_q.push_back(we);
        end
        bus.inst       = v.inst;
        bus.inst_valid = 1'b1;
        @(negedge clock);
        bus.inst_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic dbg_check(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bad [4];
        logic [15:0] r1_before_reset;
        issue_t      ie;

        bus.inst       = '0;
        bus.inst_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        check("rst_ready", {31'h0, bus.inst_ready}, 32'h1);
        check("rst_opcode", {24'h0, alu_opcode}, 32'h0);
        check("rst_a_b", {alu_a, alu_b}, 32'h0);
        check("rst_psr", {27'h0, psr}, 32'h0);
        check("rst_pulses", {30'h0, wb_valid, illegal}, 32'h0);
        check("rst_wb_bus", {12'h0, wb_addr, wb_data}, 32'h0);
        dbg_check("rst_r5", 4'd5, 16'h0000);

        vecs.push_back(mk(16'hD105, 8'h0D, 16'h0000, 16'h0005, 1'b1, 4'd1, 16'h0005));
        vecs.push_back(mk(16'h51FD, 8'h05, 16'h0005, 16'hFFFD, 1'b1, 4'd1, 16'h0002));
        vecs.push_back(mk(16'h0251, 8'h05, 16'h0000, 16'h0002, 1'b1, 4'd2, 16'h0002));
        vecs.push_back(mk(16'h01B2, 8'h0B, 16'h0002, 16'h0002, 1'b0, 4'd0, 16'h0000));
        vecs.push_back(mk(16'hF3AB, 8'hF0, 16'h0000, 16'h00AB, 1'b1, 4'd3, 16'hAB00));
        vecs.push_back(mk(16'h8302, 8'h80, 16'hAB00, 16'h0002, 1'b1, 4'd3, 16'hAC00));
        vecs.push_back(mk(16'h2180, 8'h02, 16'h0002, 16'h0080, 1'b1, 4'd1, 16'h0082));
        vecs.push_back(mk(16'h9180, 8'h09, 16'h0082, 16'hFF80, 1'b1, 4'd1, 16'h0102));
        vecs.push_back(mk(16'h8342, 8'h84, 16'hAC00, 16'h0002, 1'b1, 4'd3, 16'hB000));
        vecs.push_back(mk(16'h0123, 8'h02, 16'h0102, 16'hB000, 1'b1, 4'd1, 16'hB102));
        vecs.push_back(mk(16'h04D3, 8'h0D, 16'h0000, 16'hB000, 1'b1, 4'd4, 16'hB000));
        vecs.push_back(mk(16'h14FF, 8'h01, 16'hB000, 16'h00FF, 1'b1, 4'd4, 16'h0000));

        foreach (vecs[i]) begin
            run_inst(vecs[i]);
            if (vecs[i].op == 8'h0B) begin
                check("cmp_psr_eq", {31'h0, psr[PSR_EQ]}, 32'h1);
                check("cmp_psr_low", {31'h0, psr[PSR_LOW]}, 32'h0);
                dbg_check("cmp_r1_kept", 4'd1, 16'h0002);
                dbg_check("cmp_r2_kept", 4'd2, 16'h0002);
            end
        end

        dbg_check("final_r1", 4'd1, 16'hB102);
        dbg_check("final_r2", 4'd2, 16'h0002);
        dbg_check("final_r3", 4'd3, 16'hB000);
        dbg_check("final_r4", 4'd4, 16'h0000);
        r1_before_reset = 16'hB102;

        bad[0] = 16'h4000; bad[1] = 16'h0071; bad[2] = 16'h8020; bad[3] = 16'hC5AA;
        foreach (bad[i]) begin
            wait_ready();
            bus.inst       = bad[i];
            bus.inst_valid = 1'b1;
            @(negedge clock);
            bus.inst_valid = 1'b0;
            check("illegal_pulse", {31'h0, illegal}, 32'h1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            check("trap_set", {31'h0, trap}, 32'h1);
            check("ready_trapped", {31'h0, bus.inst_ready}, 32'h0);
            repeat (2) @(negedge clock);
            check("ready_still_trapped", {31'h0, bus.inst_ready}, 32'h0);
            pulse_reset();
            check("trap_cleared", {31'h0, trap}, 32'h0);
            r1_before_reset = 16'h0000;
`else
            check("ready_after_illegal", {31'h0, bus.inst_ready}, 32'h1);
            @(negedge clock);
`endif
            check("illegal_one_shot", {31'h0, illegal}, 32'h0);
        end

        // Reset lands while MOVI R1,#-1 is in EXEC: nothing may be written back.
        wait_ready();
        ie.op = 8'h0D; ie.a = r1_before_reset; ie.b = 16'hFFFF;
        issue_q.push_back(ie);
        bus.inst       = 16'hD1FF;
        bus.inst_valid = 1'b1;
        @(negedge clock);
        bus.inst_valid = 1'b0;
        pulse_reset();
        check("ready_after_reset", {31'h0, bus.inst_ready}, 32'h1);
        check("no_wb_after_reset", {31'h0, wb_valid}, 32'h0);
        dbg_check("r1_after_reset", 4'd1, 16'h0000);
        repeat (4) @(negedge clock);
        dbg_check("r1_still_zero", 4'd1, 16'h0000);

        check("issue_q_drained", issue_q.size(), 32'h0);
        check("wb_q_drained", wb_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Front end and writeback end of the ALU interface.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes RType/IType formats into the ALU's 8-bit opcode.
- Reads operands from an internal register file and drives opcode, rdataA and rdataB.
- Captures the ALU's registered result and PSR one cycle later, then writes back to the register file.
- Sits between the instruction source (FSM/sequencer) and the ALU. Executes strictly serially: one instruction per 3 cycles.

Parameters:
- NUM_REGS, 16: register-file depth; register addresses are always inst[11:8] / inst[3:0].
- IMM_SEXT, 1: 1 = arithmetic immediates sign-extended from imm8; 0 = zero-extended. Logical immediates (AND/OR/XOR) are always zero-extended.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- inst  in  16  instruction word
- inst_valid  in  1  inst is valid
- inst_ready  out  1  block can accept an instruction
- alu_opcode  out  8  to ALU opcode
- alu_a  out  16  to ALU rdataA
- alu_b  out  16  to ALU rdataB
- alu_result  in  16  from ALU result
- alu_psr  in  5  from ALU psrOut
- psr  out  5  last captured PSR
- wb_valid  out  1  one-cycle pulse on register write
- wb_addr  out  4  written register
- wb_data  out  16  written value
- illegal  out  1  one-cycle pulse on illegal decode
- dbg_addr  in  4  debug read address
- dbg_data  out  16  combinational rf[dbg_addr]

Behaviour:
- Reset (reset==0 at posedge):
  - state IDLE; all registers 0.
  - alu_opcode=8'h00, alu_a=alu_b=0, psr=0.
  - wb_valid=illegal=0; wb_addr=0, wb_data=0.
  - inst_ready is 1 in the first cycle after reset.
  - Reset overrides everything, including an in-flight instruction: no writeback occurs.
- FSM: IDLE -> EXEC -> WB -> IDLE.
  - inst_ready = (state==IDLE).
  - IDLE: on inst_valid, decode and register alu_opcode/alu_a/alu_b at that edge, then go to EXEC. Illegal decode: pulse illegal, stay in IDLE, alu_opcode stays 8'h00.
  - EXEC: hold outputs; the ALU samples at the end of this cycle.
  - WB: capture alu_result/alu_psr. If the instruction writes, rf[dest]<=alu_result and pulse wb_valid with wb_addr/wb_data. psr<=alu_psr for every instruction. alu_opcode<=8'h00; go to IDLE.
- Outside EXEC, alu_opcode=8'h00 (ALU idle/zero).
- Decode, with maj=inst[15:12], dest=inst[11:8], ext=inst[7:4], src=inst[3:0], imm8=inst[7:0]:
  - maj 0000, ext in {1,2,3,5,6,9,B,D}: opcode={0000,ext}, A=rf[dest], B=rf[src].
  - maj in {1,2,3,5,6,9,B,D}: IType. opcode={0000,maj}, A=rf[dest], B=extended imm8.
  - maj 1000, ext 0000/0001: opcode={1000,ext}, B={12'b0,src}.
  - maj 1000, ext 0100: opcode=8'h84, B=rf[src].
  - maj 1111: opcode=8'hF0, B={8'b0,imm8}.
  - Everything else is illegal, including maj 0100 (memory ops are out of scope).
- No writeback for CMP (RType ext B or IType maj B). All other legal instructions write dest.
- Arithmetic wraps at 16 bits. Overflow indication comes only from the ALU PSR.
- Simultaneous debug read of a register being written returns the old value that cycle.
- inst_valid outside IDLE is ignored; the source must hold inst until ready.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: an illegal decode also sets a sticky output trap (1 bit, reset 0). While trap=1, inst_ready stays 0; only reset clears it.
- Not defined: the trap port is absent and illegal instructions are dropped as NOPs after the illegal pulse.

Decomposition:
- Package alu_issue_pkg holds:
  - major/ext opcode constants (OP_RTYPE, OP_LSH, OP_LUI, EXT_AND ... EXT_MOV, EXT_CMP);
  - state enum IDLE/EXEC/WB;
  - PSR bit indices (PSR_LOW=1, PSR_FLAG=2, PSR_EQ=3, PSR_NEG=4).
- One sub-module, alu_issue_decode: purely combinational inst -> {opcode, a_sel, b_sel, imm, writes, illegal}.
- Register file inline.

Test Plan:
- Reset, then 0xD105 (MOVI R1,#5) -> opcode 8'h0D, B=5; 3 cycles later wb_valid, wb_addr=1, wb_data=0x0005.
- 0x51FD (ADDI R1,#-3) after the above -> B=0xFFFD, R1=0x0002. 0x0251 (ADD R2,R1) -> R2=0x0002.
- 0x01B2 (CMP R1,R2) with R1=R2=2 -> no wb_valid, psr[3]=1, psr[1]=0. R1 and R2 unchanged.
- 0xF3AB (LUI R3) then 0x8302 (left shift by imm 2) -> R3=0xAB00, then 0xAC00. Opcodes 8'hF0 and 8'h80 observed.
- 0x4000 -> illegal pulse, no wb_valid, inst_ready stays 1. With the trap macro: trap=1, inst_ready=0 until reset.
- Reset asserted during EXEC of 0xD1FF -> no wb_valid. R1 reads 0 via dbg_addr=1; inst_ready=1 one cycle after reset release.
